acc_reduce_unit: RTL and testbench

- Parametrised multi-core floating-point accumulator block.
- Provides N_ACC architectural accumulators; each accepts add requests from N_CORE cores.
- Per accumulator, one request per adder window is chosen by GC-stamp priority (oldest or newest), restricted to valid requesters, with a deterministic tie-break.
- Sits beside the parent FPR file; acc_value feeds the top N_ACC FPR slots and the fork broadcast.

---
 rtl/acc_pkg.sv | 68 ++++++
 rtl/acc_reduce_unit_if.sv | 15 +
 rtl/acc_stamp_arbiter.sv | 34 +++
 rtl/acc_reduce_unit.sv | 136 +++++++++++++
 tb/tb_acc_reduce_unit.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared constants, request record and fp32 adder for the accumulator-reduce block.
// Latency: n/a (declarations plus a combinational fp32 add function).
// Backpressure: n/a.
package acc_pkg;

  localparam int N_CORE              = 7;
  localparam int N_ACC               = 3;
  localparam int GC_WIDTH            = 16;
  localparam int ACC_LATENCY_DEFAULT = 6;
  localparam int IDX_W               = $clog2(N_ACC);
  localparam int CORE_W              = $clog2(N_CORE);

  typedef struct packed {
    logic                valid;
    logic [31:0]         data;
    logic [GC_WIDTH-1:0] stamp;
  } acc_req_t;

  // fp32 add with round-to-nearest-even. Denormal inputs and results are
  // flushed to zero; Inf/NaN operands are not given special treatment.
  function automatic logic [31:0] fadd_core(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [8:0]  e, d;
    logic [27:0] mx, my, s;
    logic        stk, up;
    logic [24:0] m;
    // x always carries the larger magnitude, so it also fixes the result sign
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    if (x[30:23] == 8'd0) return {x[31] & y[31], 31'd0};
    if (y[30:23] == 8'd0) return x;
    e   = {1'b0, x[30:23]};
    d   = {1'b0, x[30:23]} - {1'b0, y[30:23]};
    mx  = {2'b01, x[22:0], 3'b000};
    my  = {2'b01, y[22:0], 3'b000};
    stk = 1'b0;
    for (int i = 0; i < 27; i++) begin
      if (d > 9'(i)) begin
        stk = stk | my[0];
        my  = my >> 1;
      end
    end
    my = my | {27'd0, stk};
    if (x[31] == y[31]) s = mx + my;
    else                s = mx - my;
    if (s == 28'd0) return 32'd0;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 9'd1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!s[26]) begin
        s = s << 1;
        e = e - 9'd1;
      end
    end
    up = s[2] & (s[1] | s[0] | s[3]);
    m  = {1'b0, s[26:3]} + {24'd0, up};
    if (m[24]) begin
      m = m >> 1;
      e = e + 9'd1;
    end
    if (e[8] || e == 9'd0 || !m[23]) return {x[31], 31'd0};
    if (e >= 9'd255) return {x[31], 8'hFF, 23'd0};
    return {x[31], e[7:0], m[22:0]};
  endfunction

endpackage

// File: rtl/acc_reduce_unit_if.sv
// Core-to-accumulator request bundle: per (core, accumulator) valid/ready, addend and GC stamp.
// Latency: n/a (wires only).
// Backpressure: ready is driven by the accumulator side, valid&&ready is a dispatch.
interface acc_reduce_unit_if;
  import acc_pkg::*;

  logic [N_CORE-1:0][N_ACC-1:0]                req_valid;
  logic [N_CORE-1:0][N_ACC-1:0]                req_ready;
  logic [N_CORE-1:0][N_ACC-1:0][31:0]          req_data;
  logic [N_CORE-1:0][N_ACC-1:0][GC_WIDTH-1:0]  req_stamp;

  modport master (output req_valid, req_data, req_stamp, input  req_ready);
  modport slave  (input  req_valid, req_data, req_stamp, output req_ready);

endinterface

// File: rtl/acc_stamp_arbiter.sv
// Picks one valid requester by signed GC stamp (largest or smallest), lowest index on ties.
// Latency: combinational.
// Backpressure: none; invalid requesters are never granted.
module acc_stamp_arbiter
  import acc_pkg::*;
(
  input  logic [N_CORE-1:0]               valid,
  input  logic [N_CORE-1:0][GC_WIDTH-1:0] stamp,
  input  logic                            dir,
  output logic [N_CORE-1:0]               grant,
  output logic [CORE_W-1:0]               grant_idx,
  output logic                            grant_vld
);

  logic signed [GC_WIDTH-1:0] best;

  // Strictly-better comparison while scanning upward keeps the lowest index on ties
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    best      = '0;
    grant     = '0;
    for (int c = 0; c < N_CORE; c++) begin
      if (valid[c] && (!grant_vld ||
          (dir ? ($signed(stamp[c]) > best) : ($signed(stamp[c]) < best)))) begin
        grant_vld = 1'b1;
        grant_idx = CORE_W'(c);
        best      = $signed(stamp[c]);
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/acc_reduce_unit.sv
// N_ACC fp32 accumulators fed by N_CORE cores via stamp arbitration; optional ACC_PERF_CNT_EN dispatch counters.
// Latency: dispatch at t commits at the end of t+LATENCY; a dispatch in the count==1 cycle chains via bypass.
// Backpressure: ready only for the arbitration winner while count<=1 and no host write to that accumulator.
module acc_reduce_unit
  import acc_pkg::*;
#(
  parameter int LATENCY = ACC_LATENCY_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  acc_reduce_unit_if.slave       req_if,
  input  logic                   stamp_dir,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [31:0]            wr_data,
  output logic                   wr_err,
  output logic [N_ACC-1:0][31:0] acc_value,
  output logic [N_ACC-1:0]       acc_idle,
  output logic                   all_ready,
  output logic                   no_req,
  output logic [N_ACC-1:0][31:0] perf_dispatch
);

  localparam int               CNT_W    = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  acc_req_t                                    req_col [N_ACC][N_CORE];
  logic [N_ACC-1:0][N_CORE-1:0]                col_vld;
  logic [N_ACC-1:0][N_CORE-1:0][GC_WIDTH-1:0]  col_stamp;
  logic [N_ACC-1:0][N_CORE-1:0]                grant;
  logic [N_ACC-1:0][CORE_W-1:0]                grant_idx;
  logic [N_ACC-1:0]                            grant_vld, wr_hit, elig, disp;
  logic [CNT_W-1:0]                            count [N_ACC];
  logic [31:0]                                 pipe [N_ACC][LATENCY];
  logic [31:0]                                 op_a [N_ACC];
  logic [31:0]                                 op_b [N_ACC];

  // Regroup the request bundle per accumulator for the arbiters
  always_comb begin
    for (int a = 0; a < N_ACC; a++) begin
      for (int c = 0; c < N_CORE; c++) begin
        req_col[a][c].valid = req_if.req_valid[c][a];
        req_col[a][c].data  = req_if.req_data[c][a];
        req_col[a][c].stamp = req_if.req_stamp[c][a];
        col_vld[a][c]       = req_col[a][c].valid;
        col_stamp[a][c]     = req_col[a][c].stamp;
      end
    end
  end

  for (genvar a = 0; a < N_ACC; a++) begin : g_arb
    acc_stamp_arbiter u_arb (
      .valid     (col_vld[a]),
      .stamp     (col_stamp[a]),
      .dir       (stamp_dir),
      .grant     (grant[a]),
      .grant_idx (grant_idx[a]),
      .grant_vld (grant_vld[a])
    );
  end

  // Host-write acceptance, dispatch eligibility, operand selection and ready
  always_comb begin
    wr_hit = '0;
    elig   = '0;
    disp   = '0;
    acc_idle = '0;
    for (int a = 0; a < N_ACC; a++) begin
      wr_hit[a]   = wr_en && (wr_idx == IDX_W'(a)) && (count[a] == '0);
      elig[a]     = (count[a] <= CNT_ONE) && !wr_hit[a];
      disp[a]     = elig[a] && grant_vld[a];
      acc_idle[a] = (count[a] == '0);
      // In the count==1 cycle the committed value is stale; take the adder output instead
      op_a[a]     = (count[a] == CNT_ONE) ? pipe[a][LATENCY-1] : acc_value[a];
      op_b[a]     = req_col[a][grant_idx[a]].data;
    end
    for (int c = 0; c < N_CORE; c++) begin
      for (int a = 0; a < N_ACC; a++) begin
        req_if.req_ready[c][a] = grant[a][c] && elig[a];
      end
    end
  end

  // Global status flags
  always_comb begin
    all_ready = 1'b1;
    for (int a = 0; a < N_ACC; a++) begin
      if (count[a] > CNT_ONE) all_ready = 1'b0;
    end
    no_req = ~|req_if.req_valid;
  end

  // In-flight window per accumulator, result commit, host load and drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_err <= 1'b0;
      for (int a = 0; a < N_ACC; a++) begin
        count[a]     <= '0;
        acc_value[a] <= '0;
      end
    end else begin
      wr_err <= wr_en && !(|wr_hit);
      for (int a = 0; a < N_ACC; a++) begin
        if (disp[a])               count[a] <= CNT_LOAD;
        else if (count[a] != '0)   count[a] <= count[a] - CNT_ONE;
        if (count[a] == CNT_ONE)   acc_value[a] <= pipe[a][LATENCY-1];
        else if (wr_hit[a])        acc_value[a] <= wr_data;
      end
    end
  end

  // Adder pipe: sum formed from the dispatch-cycle operands, delivered LATENCY cycles later
  always_ff @(posedge clk) begin
    for (int a = 0; a < N_ACC; a++) begin
      pipe[a][0] <= fadd_core(op_a[a], op_b[a]);
      for (int k = 1; k < LATENCY; k++) pipe[a][k] <= pipe[a][k-1];
    end
  end

`ifdef ACC_PERF_CNT_EN
  // Dispatch counters, free-running with natural 32-bit wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_dispatch <= '0;
    end else begin
      for (int a = 0; a < N_ACC; a++) begin
        if (disp[a]) perf_dispatch[a] <= perf_dispatch[a] + 32'd1;
      end
    end
  end
`else
  assign perf_dispatch = '0;
`endif

endmodule

// File: tb/tb_acc_reduce_unit.sv
module tb_acc_reduce_unit;
  import acc_pkg::*;

  localparam int L = 6;
`ifdef ACC_PERF_CNT_EN
  localparam int PERF_EN = 1;
`else
  localparam int PERF_EN = 0;
`endif

  logic                   clk, reset, stamp_dir, wr_en, wr_err, all_ready, no_req;
  logic [IDX_W-1:0]       wr_idx;
  logic [31:0]            wr_data;
  logic [N_ACC-1:0][31:0] acc_value, perf_dispatch;
  logic [N_ACC-1:0]       acc_idle;
  int                     vec, errs;

  acc_reduce_unit_if rif();

  acc_reduce_unit #(.LATENCY(L)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_if        (rif),
    .stamp_dir     (stamp_dir),
    .wr_en         (wr_en),
    .wr_idx        (wr_idx),
    .wr_data       (wr_data),
    .wr_err        (wr_err),
    .acc_value     (acc_value),
    .acc_idle      (acc_idle),
    .all_ready     (all_ready),
    .no_req        (no_req),
    .perf_dispatch (perf_dispatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact fp32 encoding of a small integer, via the simulator's double format
  function automatic logic [31:0] int_to_fp(input int n);
    logic [63:0] b;
    int          e;
    if (n == 0) return 32'd0;
    b = $realtobits(real'(n));
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_req();
    rif.req_valid = '0;
    rif.req_data  = '0;
    rif.req_stamp = '0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
  endtask

  task automatic do_reset();
    clear_req();
    stamp_dir = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int a = 0; a < N_ACC; a++) begin
      vec++; if (acc_value[a] !== 32'd0) begin errs++; $display("FAIL reset_value[%0d]: got %h want 0", a, acc_value[a]); end
      vec++; if (acc_idle[a] !== 1'b1) begin errs++; $display("FAIL reset_idle[%0d]: got %b want 1", a, acc_idle[a]); end
      vec++; if (perf_dispatch[a] !== 32'd0) begin errs++; $display("FAIL reset_perf[%0d]: got %0d want 0", a, perf_dispatch[a]); end
    end
    vec++; if (wr_err !== 1'b0) begin errs++; $display("FAIL reset_wr_err: got %b want 0", wr_err); end
    vec++; if (all_ready !== 1'b1) begin errs++; $display("FAIL reset_all_ready: got %b want 1", all_ready); end
    vec++; if (no_req !== 1'b1) begin errs++; $display("FAIL reset_no_req: got %b want 1", no_req); end
  endtask

  task automatic test_single_add();
    do_reset();
    rif.req_valid[2][0] = 1'b1;
    rif.req_data[2][0]  = 32'h3F800000;
    #1;
    vec++; if (rif.req_ready[2][0] !== 1'b1) begin errs++; $display("FAIL single_ready: got %b want 1", rif.req_ready[2][0]); end
    tick(); clear_req();
    for (int i = 1; i < L; i++) tick();
    #1;
    vec++; if (acc_idle[0] !== 1'b0) begin errs++; $display("FAIL single_busy_tL: got %b want 0", acc_idle[0]); end
    vec++; if (acc_value[0] !== 32'd0) begin errs++; $display("FAIL single_early: got %h want 0", acc_value[0]); end
    tick(); #1;
    vec++; if (acc_value[0] !== 32'h3F800000) begin errs++; $display("FAIL single_value: got %h want 3f800000", acc_value[0]); end
    vec++; if (acc_idle[0] !== 1'b1) begin errs++; $display("FAIL single_idle: got %b want 1", acc_idle[0]); end
  endtask

  task automatic test_chain_bypass();
    do_reset();
    rif.req_valid[0][0] = 1'b1;
    rif.req_data[0][0]  = 32'h3F800000;
    #1;
    vec++; if (rif.req_ready[0][0] !== 1'b1) begin errs++; $display("FAIL chain_first_ready: got %b want 1", rif.req_ready[0][0]); end
    tick(); clear_req();
    for (int i = 1; i < L - 1; i++) tick();
    rif.req_valid[0][0] = 1'b1;
    rif.req_data[0][0]  = 32'h40000000;
    #1;
    vec++; if (rif.req_ready[0][0] !== 1'b0) begin errs++; $display("FAIL chain_early_ready: got %b want 0", rif.req_ready[0][0]); end
    tick(); #1;
    vec++; if (rif.req_ready[0][0] !== 1'b1) begin errs++; $display("FAIL chain_bypass_ready: got %b want 1", rif.req_ready[0][0]); end
    tick(); clear_req(); #1;
    vec++; if (acc_value[0] !== 32'h3F800000) begin errs++; $display("FAIL chain_mid: got %h want 3f800000", acc_value[0]); end
    for (int i = 1; i < L; i++) tick();
    #1;
    vec++; if (acc_value[0] !== 32'h3F800000) begin errs++; $display("FAIL chain_hold: got %h want 3f800000", acc_value[0]); end
    tick(); #1;
    vec++; if (acc_value[0] !== 32'h40400000) begin errs++; $display("FAIL chain_final: got %h want 40400000", acc_value[0]); end
  endtask

  task automatic test_arbitration();
    logic [N_CORE-1:0] got;
    do_reset();
    rif.req_valid[1][1] = 1'b1; rif.req_stamp[1][1] = 16'd5;
    rif.req_valid[4][1] = 1'b1; rif.req_stamp[4][1] = 16'hFFFD;
    rif.req_valid[6][1] = 1'b1; rif.req_stamp[6][1] = 16'd5;
    stamp_dir = 1'b1;
    #1;
    for (int c = 0; c < N_CORE; c++) got[c] = rif.req_ready[c][1];
    vec++; if (got !== 7'b0000010) begin errs++; $display("FAIL arb_newest: got %b want 0000010", got); end
    vec++; if (no_req !== 1'b0) begin errs++; $display("FAIL arb_no_req: got %b want 0", no_req); end
    stamp_dir = 1'b0;
    #1;
    for (int c = 0; c < N_CORE; c++) got[c] = rif.req_ready[c][1];
    vec++; if (got !== 7'b0010000) begin errs++; $display("FAIL arb_oldest: got %b want 0010000", got); end
    clear_req();
    stamp_dir = 1'b1;
  endtask

  task automatic test_write_conflict();
    do_reset();
    rif.req_valid[3][2] = 1'b1;
    rif.req_data[3][2]  = 32'h3F800000;
    tick(); clear_req();
    for (int i = 0; i < 3; i++) tick();
    wr_en = 1'b1; wr_idx = 2'd2; wr_data = 32'h40000000;
    #1;
    vec++; if (acc_idle[2] !== 1'b0) begin errs++; $display("FAIL wr_busy_idle: got %b want 0", acc_idle[2]); end
    tick(); wr_en = 1'b0; #1;
    vec++; if (wr_err !== 1'b1) begin errs++; $display("FAIL wr_busy_err: got %b want 1", wr_err); end
    vec++; if (acc_value[2] !== 32'd0) begin errs++; $display("FAIL wr_busy_value: got %h want 0", acc_value[2]); end
    tick(); #1;
    vec++; if (wr_err !== 1'b0) begin errs++; $display("FAIL wr_err_pulse: got %b want 0", wr_err); end
    tick(); #1;
    vec++; if (acc_value[2] !== 32'h3F800000) begin errs++; $display("FAIL wr_dropped_value: got %h want 3f800000", acc_value[2]); end
    wr_en = 1'b1; wr_idx = 2'd2; wr_data = 32'h40000000;
    rif.req_valid[0][2] = 1'b1;
    rif.req_data[0][2]  = 32'h3F800000;
    #1;
    vec++; if (rif.req_ready[0][2] !== 1'b0) begin errs++; $display("FAIL wr_blocks_ready: got %b want 0", rif.req_ready[0][2]); end
    tick(); clear_req(); #1;
    vec++; if (acc_value[2] !== 32'h40000000) begin errs++; $display("FAIL wr_load_value: got %h want 40000000", acc_value[2]); end
    vec++; if (wr_err !== 1'b0) begin errs++; $display("FAIL wr_load_err: got %b want 0", wr_err); end
    vec++; if (acc_idle[2] !== 1'b1) begin errs++; $display("FAIL wr_load_idle: got %b want 1", acc_idle[2]); end
    wr_en = 1'b1; wr_idx = 2'd3; wr_data = 32'h12345678;
    tick(); clear_req(); #1;
    vec++; if (wr_err !== 1'b1) begin errs++; $display("FAIL wr_bad_idx_err: got %b want 1", wr_err); end
    vec++; if (acc_value[2] !== 32'h40000000) begin errs++; $display("FAIL wr_bad_idx_value: got %h want 40000000", acc_value[2]); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rif.req_valid[5][0] = 1'b1;
    rif.req_data[5][0]  = 32'h3F800000;
    tick(); clear_req();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vec++; if (acc_idle[0] !== 1'b1) begin errs++; $display("FAIL midrst_idle: got %b want 1", acc_idle[0]); end
    vec++; if (acc_value[0] !== 32'd0) begin errs++; $display("FAIL midrst_value: got %h want 0", acc_value[0]); end
    for (int i = 0; i < L + 2; i++) tick();
    #1;
    vec++; if (acc_value[0] !== 32'd0) begin errs++; $display("FAIL midrst_late_value: got %h want 0", acc_value[0]); end
  endtask

  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rif.req_valid[1][1] = 1'b1;
      rif.req_data[1][1]  = int_to_fp(i + 1);
      #1;
      vec++; if (rif.req_ready[1][1] !== 1'b1) begin errs++; $display("FAIL perf_ready[%0d]: got %b want 1", i, rif.req_ready[1][1]); end
      tick(); clear_req();
      for (int k = 1; k < L; k++) tick();
    end
    for (int k = 0; k < 2; k++) tick();
    #1;
    vec++; if (perf_dispatch[1] !== 32'(5 * PERF_EN)) begin errs++; $display("FAIL perf_count: got %0d want %0d", perf_dispatch[1], 5 * PERF_EN); end
    vec++; if (perf_dispatch[0] !== 32'd0) begin errs++; $display("FAIL perf_other: got %0d want 0", perf_dispatch[0]); end
    vec++; if (acc_value[1] !== int_to_fp(15)) begin errs++; $display("FAIL perf_sum: got %h want %h", acc_value[1], int_to_fp(15)); end
  endtask

  // Reference: an accumulator is free LATENCY cycles after its last dispatch,
  // and the running integer sum becomes visible LATENCY+1 cycles after dispatch.
  task automatic test_random();
    int last [N_ACC];
    int sum [N_ACC];
    int comm [N_ACC];
    int pcnt [N_ACC];
    int q_cyc [N_ACC][$];
    int q_val [N_ACC][$];
    int dv [N_CORE][N_ACC];
    int sv [N_CORE][N_ACC];
    bit vv [N_CORE][N_ACC];
    logic [N_CORE-1:0] exp_rdy, got_rdy;
    int  cyc, best, win;
    bit  dir, any, el, all_ok, any_v;
    do_reset();
    cyc = 0;
    for (int a = 0; a < N_ACC; a++) begin
      last[a] = -1000; sum[a] = 0; comm[a] = 0; pcnt[a] = 0;
    end
    for (int step = 0; step < 400; step++) begin
      dir = 1'($urandom_range(0, 1));
      stamp_dir = dir;
      any_v = 1'b0;
      for (int c = 0; c < N_CORE; c++) begin
        for (int a = 0; a < N_ACC; a++) begin
          vv[c][a] = ($urandom_range(0, 3) == 0);
          sv[c][a] = int'($urandom_range(0, 12)) - 6;
          dv[c][a] = int'($urandom_range(0, 100)) - 50;
          rif.req_valid[c][a] = vv[c][a];
          rif.req_stamp[c][a] = GC_WIDTH'(sv[c][a]);
          rif.req_data[c][a]  = int_to_fp(dv[c][a]);
          any_v = any_v | vv[c][a];
        end
      end
      #1;
      all_ok = 1'b1;
      for (int a = 0; a < N_ACC; a++) begin
        while (q_cyc[a].size() > 0 && q_cyc[a][0] <= cyc) begin
          comm[a] = q_val[a][0];
          void'(q_cyc[a].pop_front());
          void'(q_val[a].pop_front());
        end
        any = 1'b0; best = 0;
        for (int c = 0; c < N_CORE; c++) begin
          if (vv[c][a]) begin
            if (!any) best = sv[c][a];
            else if (dir) best = (sv[c][a] > best) ? sv[c][a] : best;
            else          best = (sv[c][a] < best) ? sv[c][a] : best;
            any = 1'b1;
          end
        end
        win = -1;
        for (int c = 0; c < N_CORE; c++) if (vv[c][a] && sv[c][a] == best && win < 0) win = c;
        el = (cyc - last[a]) >= L;
        exp_rdy = '0;
        if (el && any) exp_rdy[win] = 1'b1;
        for (int c = 0; c < N_CORE; c++) got_rdy[c] = rif.req_ready[c][a];
        vec++; if (got_rdy !== exp_rdy) begin errs++; $display("FAIL rnd_ready acc%0d cyc%0d: got %b want %b", a, cyc, got_rdy, exp_rdy); end
        vec++; if (acc_value[a] !== int_to_fp(comm[a])) begin errs++; $display("FAIL rnd_value acc%0d cyc%0d: got %h want %h", a, cyc, acc_value[a], int_to_fp(comm[a])); end
        vec++; if (acc_idle[a] !== ((cyc - last[a]) >= L + 1)) begin errs++; $display("FAIL rnd_idle acc%0d cyc%0d: got %b want %b", a, cyc, acc_idle[a], ((cyc - last[a]) >= L + 1)); end
        all_ok = all_ok & el;
        if (el && any) begin
          sum[a] += dv[win][a];
          last[a] = cyc;
          pcnt[a]++;
          q_cyc[a].push_back(cyc + L + 1);
          q_val[a].push_back(sum[a]);
        end
      end
      vec++; if (all_ready !== all_ok) begin errs++; $display("FAIL rnd_all_ready cyc%0d: got %b want %b", cyc, all_ready, all_ok); end
      vec++; if (no_req !== !any_v) begin errs++; $display("FAIL rnd_no_req cyc%0d: got %b want %b", cyc, no_req, !any_v); end
      vec++; if (wr_err !== 1'b0) begin errs++; $display("FAIL rnd_wr_err cyc%0d: got %b want 0", cyc, wr_err); end
      tick();
      cyc++;
    end
    clear_req();
    for (int i = 0; i < L + 2; i++) tick();
    #1;
    for (int a = 0; a < N_ACC; a++) begin
      vec++; if (acc_value[a] !== int_to_fp(sum[a])) begin errs++; $display("FAIL rnd_final acc%0d: got %h want %h", a, acc_value[a], int_to_fp(sum[a])); end
      vec++; if (perf_dispatch[a] !== 32'(pcnt[a] * PERF_EN)) begin errs++; $display("FAIL rnd_perf acc%0d: got %0d want %0d", a, perf_dispatch[a], pcnt[a] * PERF_EN); end
    end
  endtask

  initial begin
    vec = 0;
    errs = 0;
    wr_idx = '0;
    test_reset();
    test_single_add();
    test_chain_bypass();
    test_arbitration();
    test_write_conflict();
    test_reset_midflight();
    test_perf();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
